vga_timing_gen: RTL and testbench

Raster timing generator sitting directly upstream of the pixel colour renderer. It produces the x/y scan coordinates and active_pixels strobe the renderer consumes, plus the VGA sync/blank/clock signals driven to the DAC. It also emits a once-per-frame tick that the game logic uses to update player and lava state during vertical blank. Timing is 640x480@60 Hz from a 50 MHz system clock.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_pix_div.sv | 46 ++++
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 Hz raster constants shared by the VGA timing slice.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_COORD_W      = 10;

    localparam int c_H_VISIBLE    = 640;
    localparam int c_H_FRONT      = 16;
    localparam int c_H_SYNC       = 96;
    localparam int c_H_BACK       = 48;
    localparam int c_H_TOTAL      = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int c_H_SYNC_START = c_H_VISIBLE + c_H_FRONT;
    localparam int c_H_SYNC_END   = c_H_SYNC_START + c_H_SYNC;

    localparam int c_V_VISIBLE    = 480;
    localparam int c_V_FRONT      = 10;
    localparam int c_V_SYNC       = 2;
    localparam int c_V_BACK       = 33;
    localparam int c_V_TOTAL      = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;
    localparam int c_V_SYNC_START = c_V_VISIBLE + c_V_FRONT;
    localparam int c_V_SYNC_END   = c_V_SYNC_START + c_V_SYNC;

    typedef logic [c_COORD_W-1:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/vga_pix_div.sv
`default_nettype none
// ============================================================================
// Module   : vga_pix_div
// Brief    : System-clock to pixel-rate divider; registered pix_en strobe and DAC clock.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic o_pix_en,
    output logic o_vga_clk
);

    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV / 2);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_next;
    logic               r_pix_en;
    logic               r_vga_clk;

    always_comb begin
        w_div_next = (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_W'(1);
    end

    // Strobe and DAC clock are decoded from the next count so they line up with r_div_cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_pix_en  <= 1'b0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_pix_en  <= (w_div_next == c_DIV_LAST);
            r_vga_clk <= (w_div_next >= c_DIV_HALF);
        end
    end

    assign o_pix_en  = r_pix_en;
    assign o_vga_clk = r_vga_clk;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing (scan coords, syncs, blank, frame tick).
//            Define VGA_SYNC_DELAY_EN to delay HS/VS/BLANK_N by SYNC_DELAY pixels.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK
`ifdef VGA_SYNC_DELAY_EN
    ,
    parameter int SYNC_DELAY = 2
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [c_COORD_W-1:0] x,
    output logic [c_COORD_W-1:0] y,
    output logic                 active_pixels,
    output logic                 pix_en,
    output logic                 frame_tick,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK_N,
    output logic                 VGA_SYNC_N,
    output logic                 VGA_CLK
);

    localparam coord_t c_H_LAST   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t c_V_LAST   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t c_H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t c_V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t c_HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t c_HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t c_VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t c_VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic   w_pix_en;
    logic   w_vga_clk;
    coord_t r_h_cnt;
    coord_t r_v_cnt;
    coord_t w_h_next;
    coord_t w_v_next;
    logic   w_visible;
    logic   w_hs;
    logic   w_vs;
    logic   w_tick;
    logic   r_active;
    logic   r_hs;
    logic   r_vs;
    logic   r_frame_tick;

    vga_pix_div #(
        .CLK_DIV   (CLK_DIV)
    ) u_pix_div (
        .clk       (clk),
        .rst       (rst),
        .o_pix_en  (w_pix_en),
        .o_vga_clk (w_vga_clk)
    );

    // Decode from the next counter values so every output register matches the counters.
    always_comb begin
        w_h_next = r_h_cnt + coord_t'(1);
        w_v_next = r_v_cnt;
        if (r_h_cnt == c_H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + coord_t'(1);
        end
        w_visible = (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
        w_hs      = !((w_h_next >= c_HS_START) && (w_h_next < c_HS_END));
        w_vs      = !((w_v_next >= c_VS_START) && (w_v_next < c_VS_END));
        w_tick    = (w_h_next == '0) && (w_v_next == c_V_VIS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt      <= c_H_LAST;
            r_v_cnt      <= c_V_LAST;
            r_active     <= 1'b0;
            r_hs         <= 1'b1;
            r_vs         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (w_pix_en) begin
                r_h_cnt      <= w_h_next;
                r_v_cnt      <= w_v_next;
                r_active     <= w_visible;
                r_hs         <= w_hs;
                r_vs         <= w_vs;
                r_frame_tick <= w_tick;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [SYNC_DELAY-1:0] r_hs_sr;
    logic [SYNC_DELAY-1:0] r_vs_sr;
    logic [SYNC_DELAY-1:0] r_blank_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs_sr    <= '1;
            r_vs_sr    <= '1;
            r_blank_sr <= '0;
        end else if (w_pix_en) begin
            r_hs_sr[0]    <= r_hs;
            r_vs_sr[0]    <= r_vs;
            r_blank_sr[0] <= r_active;
            for (int i = 1; i < SYNC_DELAY; i++) begin
                r_hs_sr[i]    <= r_hs_sr[i-1];
                r_vs_sr[i]    <= r_vs_sr[i-1];
                r_blank_sr[i] <= r_blank_sr[i-1];
            end
        end
    end

    assign VGA_HS      = r_hs_sr[SYNC_DELAY-1];
    assign VGA_VS      = r_vs_sr[SYNC_DELAY-1];
    assign VGA_BLANK_N = r_blank_sr[SYNC_DELAY-1];
`else
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_active;
`endif

    assign x             = r_h_cnt;
    assign y             = r_v_cnt;
    assign active_pixels = r_active;
    assign pix_en        = w_pix_en;
    assign frame_tick    = r_frame_tick;
    assign VGA_SYNC_N    = 1'b0;
    assign VGA_CLK       = w_vga_clk;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed bench for vga_timing_gen; standard horizontal timing with a
//            shortened 15-line frame (8 visible, VS on lines 10-11).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int c_D = 2;
`else
    localparam int c_D = 0;
`endif
    localparam int c_VT = 15;
    localparam int c_VV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic       active_pixels;
    logic       pix_en;
    logic       frame_tick;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    int tick_x   = -1;
    int tick_y   = -1;
    bit stuck    = 1'b0;

    always #10 clk = ~clk;

    vga_timing_gen #(
        .V_VISIBLE     (8),
        .V_FRONT       (2),
        .V_SYNC        (2),
        .V_BACK        (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .x             (x),
        .y             (y),
        .active_pixels (active_pixels),
        .pix_en        (pix_en),
        .frame_tick    (frame_tick),
        .VGA_HS        (VGA_HS),
        .VGA_VS        (VGA_VS),
        .VGA_BLANK_N   (VGA_BLANK_N),
        .VGA_SYNC_N    (VGA_SYNC_N),
        .VGA_CLK       (VGA_CLK)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance exactly one pixel; returns #1 after the edge that moved the counters.
    task automatic pix_step();
        bit p;
        int n;
        if (stuck) return;
        n = 0;
        do begin
            p = pix_en;
            @(posedge clk);
            #1;
            if (frame_tick) begin
                tick_cnt++;
                tick_x = int'(x);
                tick_y = int'(y);
            end
            n++;
        end while (!p && n < 8);
        if (!p) begin
            stuck = 1'b1;
            check_eq("pix_en_timeout", 0, 1);
        end
    endtask

    task automatic run_to(input int xt, input int yt, input int cap);
        int steps;
        steps = 0;
        while (!(int'(x) == xt && int'(y) == yt) && steps < cap && !stuck) begin
            pix_step();
            steps++;
        end
        if (!(int'(x) == xt && int'(y) == yt))
            check_eq($sformatf("reach_%0d_%0d", xt, yt), 0, 1);
    endtask

    initial begin
        #1900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    pe, rises, hs_fall, hs_rise, hs_low, act_fall, blk_fall, last_x;
        int    steps, vs_fall_y, vs_rise_y, vs_low, tc;
        time   t0, t1;
        logic  pc, hs_p, act_p, blk_p, vs_p;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_x",       int'(x), 799);
        check_eq("rst_y",       int'(y), c_VT - 1);
        check_eq("rst_active",  int'(active_pixels), 0);
        check_eq("rst_blank_n", int'(VGA_BLANK_N), 0);
        check_eq("rst_hs",      int'(VGA_HS), 1);
        check_eq("rst_vs",      int'(VGA_VS), 1);
        check_eq("rst_tick",    int'(frame_tick), 0);
        check_eq("rst_pix_en",  int'(pix_en), 0);
        check_eq("rst_vga_clk", int'(VGA_CLK), 0);
        check_eq("rst_sync_n",  int'(VGA_SYNC_N), 0);

        // First pixel after release
        rst = 1'b1;
        pix_step();
        check_eq("first_x",       int'(x), 0);
        check_eq("first_y",       int'(y), 0);
        check_eq("first_active",  int'(active_pixels), 1);
        check_eq("first_blank_n", int'(VGA_BLANK_N), (c_D == 0) ? 1 : 0);
        check_eq("first_hs",      int'(VGA_HS), 1);

        // Strobe cadence and DAC clock period (two system clocks of 20 units)
        pe = 0; rises = 0; t0 = 0; t1 = 0; pc = VGA_CLK;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (pix_en) pe++;
            if (VGA_CLK && !pc) begin
                if (rises == 0) t0 = $time;
                t1 = $time;
                rises++;
            end
            pc = VGA_CLK;
        end
        check_eq("pix_en_count", pe, 4);
        check_eq("vga_clk_rises", rises, 4);
        check_eq("vga_clk_period", (rises > 1) ? int'((t1 - t0) / (rises - 1)) : 0, 40);

        // Remainder of line 0
        hs_fall = -1; hs_rise = -1; hs_low = 0; act_fall = -1; blk_fall = -1; last_x = -1;
        hs_p = VGA_HS; act_p = active_pixels; blk_p = VGA_BLANK_N;
        for (int i = 0; i < 900 && !stuck; i++) begin
            last_x = int'(x);
            pix_step();
            if (x == 10'd0) break;
            if (!VGA_HS) hs_low++;
            if (hs_p && !VGA_HS) hs_fall = int'(x);
            if (!hs_p && VGA_HS) hs_rise = int'(x);
            if (act_p && !active_pixels) act_fall = int'(x);
            if (blk_p && !VGA_BLANK_N) blk_fall = int'(x);
            hs_p = VGA_HS; act_p = active_pixels; blk_p = VGA_BLANK_N;
        end
        check_eq("hs_fall_x",   hs_fall, 656 + c_D);
        check_eq("hs_rise_x",   hs_rise, 752 + c_D);
        check_eq("hs_low_px",   hs_low, 96);
        check_eq("act_fall_x",  act_fall, 640);
        check_eq("blank_fall_x", blk_fall, 640 + c_D);
        check_eq("wrap_from_x", last_x, 799);
        check_eq("wrap_y",      int'(y), 1);
        check_eq("wrap_active", int'(active_pixels), 1);

        // Reset mid-frame
        run_to(300, 3, 4000);
        check_eq("mid_active", int'(active_pixels), 1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_x",      int'(x), 799);
        check_eq("mid_rst_y",      int'(y), c_VT - 1);
        check_eq("mid_rst_hs",     int'(VGA_HS), 1);
        check_eq("mid_rst_vs",     int'(VGA_VS), 1);
        check_eq("mid_rst_active", int'(active_pixels), 0);
        check_eq("mid_rst_pix_en", int'(pix_en), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pix_step();
        check_eq("restart_x",      int'(x), 0);
        check_eq("restart_y",      int'(y), 0);
        check_eq("restart_active", int'(active_pixels), 1);

        // First frame tick
        steps = 0;
        while (tick_cnt == 0 && steps < 10000 && !stuck) begin
            pix_step();
            steps++;
        end
        check_eq("tick1_count", tick_cnt, 1);
        check_eq("tick1_x",     tick_x, 0);
        check_eq("tick1_y",     tick_y, c_VV);

        // Tick to tick, through vertical sync and the frame corner
        steps = 0; vs_fall_y = -1; vs_rise_y = -1; vs_low = 0; vs_p = VGA_VS;
        while (!(int'(x) == 799 && int'(y) == c_VT - 1) && steps < 13000 && !stuck) begin
            pix_step();
            steps++;
            if (!VGA_VS) vs_low++;
            if (vs_p && !VGA_VS) vs_fall_y = int'(y);
            if (!vs_p && VGA_VS) vs_rise_y = int'(y);
            vs_p = VGA_VS;
        end
        check_eq("vs_fall_y",  vs_fall_y, 10);
        check_eq("vs_rise_y",  vs_rise_y, 12);
        check_eq("vs_low_px",  vs_low, 1600);
        tc = tick_cnt;
        pix_step();
        steps++;
        check_eq("corner_x",      int'(x), 0);
        check_eq("corner_y",      int'(y), 0);
        check_eq("corner_active", int'(active_pixels), 1);
        check_eq("corner_tick",   tick_cnt - tc, 0);
        while (tick_cnt == 1 && steps < 13000 && !stuck) begin
            pix_step();
            steps++;
        end
        check_eq("frame_pixels", steps, 800 * c_VT);
        check_eq("tick2_count",  tick_cnt, 2);
        check_eq("tick2_y",      tick_y, c_VV);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
